// File: rtl/cfg_loader_pkg.sv
// Shared types, constants and the serial CRC-16-CCITT step for the chain loader.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    READBACK = 2'd2
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One MSB-first serial update of the CRC register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    return {crc[14:0], 1'b0} ^ (((crc[15] ^ bit_in) == 1'b1) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator; clear has priority over enable.
module cfg_crc16_serial
  import cfg_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_crc <= CRC16_INIT;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises config words into the switch-box scan chain, then rotates the chain once
// to compare a readback CRC against the load CRC.
//   state    | meaning
//   IDLE     | waiting for start; CRCs held at init
//   LOAD     | accepting words, shifting them in bit 0 first
//   READBACK | feeding chain tail back to head for one full rotation
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int CHAIN_BITS = 128
) (
  input  logic              i_prog_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_cfg_data,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  output logic              o_prog_in,
  output logic              o_prog_en,
  input  logic              i_chain_tail,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_crc_ok,
  output logic [15:0]       o_crc_val
);

  localparam int NWORDS = CHAIN_BITS / WORD_W;
  localparam int CW     = $clog2(CHAIN_BITS + 1);
  localparam int IW     = $clog2(WORD_W);
  localparam int AW     = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);
  localparam logic [AW-1:0] ACC_MAX  = AW'(NWORDS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_word;
  logic              r_full;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_acc;
  logic              r_prog_en;
  logic              r_done;
  logic              r_crc_ok;
  logic [15:0]       r_crc_val;

  logic              w_shift_l;
  logic              w_shift_r;
  logic              w_cnt_end;
  logic              w_last_bit;
  logic              w_ready;
  logic              w_accept;
  logic              w_full_nxt;
  logic              w_en_nxt;
  logic              w_prog_in;
  logic [15:0]       w_crc_l;
  logic [15:0]       w_crc_r;

  assign w_shift_l  = (r_state == LOAD) && r_full;
  assign w_shift_r  = (r_state == READBACK);
  assign w_cnt_end  = (r_cnt == CNT_LAST);
  assign w_last_bit = w_shift_l && (r_idx == IDX_LAST);

  always_ff @(posedge i_prog_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (i_start) w_state_nxt = LOAD;
      LOAD:     if (w_shift_l && w_cnt_end) w_state_nxt = READBACK;
      READBACK: if (w_cnt_end) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready    = (r_state == LOAD) && (r_acc != ACC_MAX) && (!r_full || w_last_bit);
    w_accept   = w_ready && i_cfg_valid;
    w_prog_in  = 1'b0;
    if (r_state == LOAD) begin
      w_prog_in = r_word[r_idx];
    end else if (r_state == READBACK) begin
      w_prog_in = i_chain_tail;
    end
    w_full_nxt = r_full;
    if (w_accept) begin
      w_full_nxt = 1'b1;
    end else if (w_last_bit) begin
      w_full_nxt = 1'b0;
    end
    // prog_en is a flop: precompute what the decode will be next cycle
    w_en_nxt   = ((w_state_nxt == LOAD) && w_full_nxt) || (w_state_nxt == READBACK);
  end

  always_ff @(posedge i_prog_clk) begin
    if (i_rst) begin
      r_word    <= '0;
      r_full    <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_prog_en <= 1'b0;
      r_done    <= 1'b0;
      r_crc_ok  <= 1'b0;
      r_crc_val <= '0;
    end else begin
      r_done    <= 1'b0;
      r_prog_en <= w_en_nxt;
      case (r_state)
        IDLE: begin
          r_full <= 1'b0;
          r_idx  <= '0;
          r_cnt  <= '0;
          r_acc  <= '0;
          if (i_start) begin
            r_crc_ok  <= 1'b0;
            r_crc_val <= '0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_word <= i_cfg_data;
            r_acc  <= r_acc + 1'b1;
          end
          r_full <= w_full_nxt;
          if (w_shift_l) begin
            r_idx <= r_idx + 1'b1;
            r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
          end
        end
        READBACK: begin
          r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
          if (w_cnt_end) begin
            // last tail bit is folded in here so the verdict lands with done
            r_done    <= 1'b1;
            r_crc_ok  <= (crc16_step(w_crc_r, i_chain_tail) == w_crc_l);
            r_crc_val <= w_crc_l;
          end
        end
        default: ;
      endcase
    end
  end

  cfg_crc16_serial u_crc_l (
    .i_clk (i_prog_clk),
    .i_rst (i_rst),
    .i_clr (r_state == IDLE),
    .i_en  (w_shift_l),
    .i_bit (w_prog_in),
    .o_crc (w_crc_l)
  );

  cfg_crc16_serial u_crc_r (
    .i_clk (i_prog_clk),
    .i_rst (i_rst),
    .i_clr (r_state == IDLE),
    .i_en  (w_shift_r),
    .i_bit (i_chain_tail),
    .o_crc (w_crc_r)
  );

  assign o_cfg_ready = w_ready;
  assign o_prog_in   = w_prog_in;
  assign o_prog_en   = r_prog_en;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_crc_ok    = r_crc_ok;
  assign o_crc_val   = r_crc_val;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench: 128-bit chain (four 32-bit tiles) and a 32-bit single-tile chain.
module tb_cfg_chain_loader;

  localparam logic [127:0] WORDS = {32'h80000000, 32'hFFFF0000, 32'hA5A5A5A5, 32'h00000001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, valid, ready, prog_in, prog_en, tail, busy, done, ok;
  logic [31:0] data;
  logic [15:0] crcv;
  logic        start_b, valid_b, ready_b, pin_b, pen_b, tail_b, busy_b, done_b, ok_b;
  logic [31:0] data_b;
  logic [15:0] crcv_b;

  logic [127:0] chain = '0;
  logic [127:0] chain_pre;
  logic [31:0]  chain_b = '0;
  logic         flip_req;

  int total = 0;
  int bad   = 0;

  int           res_en, res_zero, res_acc, res_rdyrb, res_busylo, res_lat, res_dcyc;
  logic         res_done;
  logic [127:0] res_snap;

  cfg_chain_loader #(.WORD_W(32), .CHAIN_BITS(128)) dut_a (
    .i_prog_clk(clk), .i_rst(rst), .i_start(start), .i_cfg_data(data), .i_cfg_valid(valid),
    .o_cfg_ready(ready), .o_prog_in(prog_in), .o_prog_en(prog_en), .i_chain_tail(tail),
    .o_busy(busy), .o_done(done), .o_crc_ok(ok), .o_crc_val(crcv)
  );

  cfg_chain_loader #(.WORD_W(32), .CHAIN_BITS(32)) dut_b (
    .i_prog_clk(clk), .i_rst(rst), .i_start(start_b), .i_cfg_data(data_b), .i_cfg_valid(valid_b),
    .o_cfg_ready(ready_b), .o_prog_in(pin_b), .o_prog_en(pen_b), .i_chain_tail(tail_b),
    .o_busy(busy_b), .o_done(done_b), .o_crc_ok(ok_b), .o_crc_val(crcv_b)
  );

  // Tiles shift right: head enters tile0 bit 31, tail is tile3 bit 0.
  assign tail      = chain[0];
  assign tail_b    = chain_b[0];
  assign chain_pre = flip_req ? (chain ^ (128'd1 << 39)) : chain;

  always @(posedge clk) begin
    if (prog_en) chain <= {prog_in, chain_pre[127:1]};
    else         chain <= chain_pre;
  end

  always @(posedge clk) begin
    if (pen_b) chain_b <= {pin_b, chain_b[31:1]};
  end

  function automatic logic [15:0] crc_ref(input logic [127:0] s, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ s[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one load on dut_a. gap: ready-cycles to idle cfg_valid after each accept.
  // flip_at/start_at/rst_at: act at the cycle where that many prog_en cycles were seen.
  task automatic run_a(input logic [127:0] words, input int gap, input int flip_at,
                       input int start_at, input int rst_at);
    int   k, g, acc_cyc, en_cyc;
    logic pend, rose, snapped;
    k = 0; g = gap; pend = 1'b0; rose = 1'b0; snapped = 1'b0;
    acc_cyc = -1; en_cyc = -1;
    res_en = 0; res_zero = 0; res_acc = 0; res_rdyrb = 0; res_busylo = 0;
    res_done = 1'b0; res_snap = '0; res_lat = -1; res_dcyc = -1;
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (res_en == 128 && !snapped) begin
        res_snap = chain;
        snapped  = 1'b1;
      end
      if (done) begin
        res_done = 1'b1;
        res_dcyc = cyc + 1;
        break;
      end
      if (!busy) res_busylo++;
      if (prog_en) begin
        if (!rose) en_cyc = cyc;
        res_en++;
        rose = 1'b1;
      end else if (rose) begin
        res_zero++;
      end
      if (res_en > 128 && ready) res_rdyrb++;
      if (rst_at > 0 && res_en == rst_at) begin
        rst = 1'b1; valid = 1'b0; start = 1'b0;
        break;
      end
      start    = (start_at > 0 && res_en == start_at);
      flip_req = (flip_at > 0 && res_en == flip_at);
      if (pend) begin
        k++;
        res_acc++;
        g = gap;
      end
      if (k >= 4) begin
        valid = 1'b1; data = 32'hDEADBEEF;
      end else begin
        valid = (g == 0); data = words[32*k +: 32];
      end
      pend = valid && ready;
      if (pend && acc_cyc < 0) acc_cyc = cyc;
      if (!valid && ready && g > 0) g--;
    end
    res_lat  = en_cyc - acc_cyc;
    valid    = 1'b0;
    start    = 1'b0;
    flip_req = 1'b0;
  endtask

  initial begin
    int   en_b, acc_b;
    logic pend_b, done_seen_b;

    rst = 1'b1; start = 1'b0; valid = 1'b1; data = 32'hCAFEF00D; flip_req = 1'b0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;

    // 1: reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_prog_en", 32'(prog_en), 0);
    chk("rst_prog_in", 32'(prog_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_crc_ok", 32'(ok), 0);
    chk("rst_crc_val", 32'(crcv), 0);
    chk("rst_ready_idle", 32'(ready), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    valid = 1'b0;

    // 2: back-to-back words, start pulse during readback must be ignored
    run_a(WORDS, 0, 0, 200, 0);
    chk("c2_done_seen", 32'(res_done), 1);
    chk("c2_latency", res_dcyc, 2*128 + 2);
    chk("c2_first_shift", res_lat, 1);
    chk("c2_en_cycles", res_en, 256);
    chk("c2_contiguous", res_zero, 0);
    chk("c2_accepts", res_acc, 4);
    chk("c2_ready_in_rb", res_rdyrb, 0);
    chk("c2_busy_low", res_busylo, 0);
    chk_w("c2_chain_load", res_snap, WORDS);
    chk_w("c2_chain_final", chain, WORDS);
    chk("c2_prog_en_done", 32'(prog_en), 0);
    chk("c2_crc_ok", 32'(ok), 1);
    chk("c2_crc_val", 32'(crcv), 32'(crc_ref(WORDS, 128)));
    @(negedge clk);
    chk("c2_done_pulse", 32'(done), 0);
    chk("c2_idle", 32'(busy), 0);
    chk("c2_crc_ok_held", 32'(ok), 1);

    // 3: 5-cycle valid gaps create stalls between words
    run_a(WORDS, 5, 0, 0, 0);
    chk("c3_done_seen", 32'(res_done), 1);
    chk("c3_en_cycles", res_en, 256);
    chk("c3_stall_cycles", res_zero, 15);
    chk("c3_accepts", res_acc, 4);
    chk_w("c3_chain_load", res_snap, WORDS);
    chk("c3_crc_ok", 32'(ok), 1);
    chk("c3_crc_val", 32'(crcv), 32'(crc_ref(WORDS, 128)));

    // 4: corrupt tile 2 bit 7 mid-readback
    run_a(WORDS, 0, 160, 0, 0);
    chk("c4_done_seen", 32'(res_done), 1);
    chk("c4_en_cycles", res_en, 256);
    chk("c4_crc_ok", 32'(ok), 0);
    chk("c4_crc_val", 32'(crcv), 32'(crc_ref(WORDS, 128)));
    @(negedge clk);

    // 5: start while busy ignored, reset at load shift 40, then a clean reload
    run_a(WORDS, 0, 0, 10, 40);
    chk("c5_en_before_rst", res_en, 40);
    chk("c5_contiguous", res_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("c5_rst_prog_en", 32'(prog_en), 0);
    chk("c5_rst_busy", 32'(busy), 0);
    chk("c5_rst_ready", 32'(ready), 0);
    chk("c5_rst_done", 32'(done), 0);
    run_a(WORDS, 0, 0, 0, 0);
    chk("c5_done_seen", 32'(res_done), 1);
    chk("c5_en_cycles", res_en, 256);
    chk("c5_crc_ok", 32'(ok), 1);
    chk("c5_crc_val", 32'(crcv), 32'(crc_ref(WORDS, 128)));
    chk_w("c5_chain_final", chain, WORDS);

    // 6: 32-bit chain, one word; a second word stays offered and must not be taken
    @(negedge clk);
    valid_b = 1'b1; data_b = 32'h12345678; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    en_b = 0; acc_b = 0; pend_b = 1'b0; done_seen_b = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done_b) begin
        done_seen_b = 1'b1;
        break;
      end
      if (pen_b) en_b++;
      if (pend_b) data_b = 32'hDEADBEEF;
      pend_b = valid_b && ready_b;
      if (pend_b) acc_b++;
    end
    valid_b = 1'b0;
    chk("c6_done_seen", 32'(done_seen_b), 1);
    chk("c6_en_cycles", en_b, 64);
    chk("c6_accepts", acc_b, 1);
    chk("c6_crc_ok", 32'(ok_b), 1);
    chk("c6_crc_val", 32'(crcv_b), 32'(crc_ref({96'd0, 32'h12345678}, 32)));
    chk("c6_chain", chain_b, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
